// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Purpose  : RV32I IF stage - PC, imem req/ready handshake, skid buffer, IF/ID.
//            Optional macro FETCH_PERF_CNT_EN adds fetch/bubble counters.
// Revision : 1.0
// ============================================================================
module fetch_unit #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        StallF,
   input  logic        StallD,
   input  logic        PCSrcE,
   input  logic [31:0] PCTargetE,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   output logic [31:0] InstrD,
   output logic [31:0] PCD,
   output logic [31:0] PCPlus4D,
   output logic        ValidD
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0] fetch_count,
   output logic [31:0] bubble_count
`endif
);

   typedef enum logic [1:0] {
      S_FETCH = 2'd0,
      S_HOLD  = 2'd1,
      S_DRAIN = 2'd2
   } state_t;

   state_t      r_state;
   logic [31:0] r_pcf;
   logic [31:0] r_req_addr;
   logic [31:0] r_skid;
   logic [31:0] r_skid_pc;
   logic        r_pending;   // request raised earlier in FETCH, not yet accepted

   logic        w_req;
   logic        w_accept;
   logic [31:0] w_addr_p4;
   logic        w_ld;
   logic        w_ld_valid;
   logic [31:0] w_ld_instr;
   logic [31:0] w_ld_pc;

   assign w_req     = !rst && (((r_state == S_FETCH) && (r_pending || !StallF)) ||
                               (r_state == S_DRAIN));
   assign w_accept  = w_req && imem_ready;
   assign w_addr_p4 = r_req_addr + 32'd4;
   assign imem_req  = w_req;
   assign imem_addr = r_req_addr;

   // IF/ID load decision: a redirect always forces a bubble, StallD otherwise holds.
   always_comb begin
      w_ld       = 1'b0;
      w_ld_valid = 1'b0;
      w_ld_instr = NOP_INSTR;
      w_ld_pc    = r_req_addr;
      case (r_state)
         S_FETCH: begin
            if (PCSrcE) begin
               w_ld = 1'b1;
            end else if (!StallD) begin
               w_ld = 1'b1;
               if (w_accept) begin
                  w_ld_valid = 1'b1;
                  w_ld_instr = imem_rdata;
               end
            end
         end
         S_HOLD: begin
            if (PCSrcE) begin
               w_ld = 1'b1;
            end else if (!StallD) begin
               w_ld       = 1'b1;
               w_ld_valid = 1'b1;
               w_ld_instr = r_skid;
               w_ld_pc    = r_skid_pc;
            end
         end
         S_DRAIN: begin
            w_ld = PCSrcE || !StallD;
         end
         default: begin
            w_ld = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_FETCH;
         r_pcf      <= RESET_PC;
         r_req_addr <= RESET_PC;
         r_skid     <= NOP_INSTR;
         r_skid_pc  <= 32'd0;
         r_pending  <= 1'b0;
      end else begin
         case (r_state)
            S_FETCH: begin
               if (PCSrcE) begin
                  r_pcf     <= PCTargetE;
                  r_pending <= 1'b0;
                  // An unaccepted request must finish on its old address first.
                  if (w_req && !imem_ready) begin
                     r_state <= S_DRAIN;
                  end else begin
                     r_req_addr <= PCTargetE;
                  end
               end else if (w_accept) begin
                  r_pcf      <= w_addr_p4;
                  r_req_addr <= w_addr_p4;
                  r_pending  <= 1'b0;
                  if (StallD) begin
                     r_skid    <= imem_rdata;
                     r_skid_pc <= r_req_addr;
                     r_state   <= S_HOLD;
                  end
               end else begin
                  r_pending <= w_req;
               end
            end
            S_HOLD: begin
               if (PCSrcE) begin
                  r_pcf      <= PCTargetE;
                  r_req_addr <= PCTargetE;
                  r_skid     <= NOP_INSTR;
                  r_state    <= S_FETCH;
               end else if (!StallD) begin
                  r_state <= S_FETCH;
               end
            end
            S_DRAIN: begin
               if (PCSrcE) begin
                  r_pcf <= PCTargetE;
               end
               if (imem_ready) begin
                  r_state    <= S_FETCH;
                  r_req_addr <= PCSrcE ? PCTargetE : r_pcf;
               end
            end
            default: begin
               r_state <= S_FETCH;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         InstrD   <= NOP_INSTR;
         PCD      <= 32'd0;
         PCPlus4D <= 32'd0;
         ValidD   <= 1'b0;
      end else if (w_ld) begin
         InstrD <= w_ld_instr;
         ValidD <= w_ld_valid;
         if (w_ld_valid) begin
            PCD      <= w_ld_pc;
            PCPlus4D <= w_ld_pc + 32'd4;
         end
      end
   end

`ifdef FETCH_PERF_CNT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_count  <= 32'd0;
         bubble_count <= 32'd0;
      end else if (w_ld) begin
         if (w_ld_valid) begin
            fetch_count <= fetch_count + 32'd1;
         end else begin
            bubble_count <= bubble_count + 32'd1;
         end
      end
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_unit
// Purpose  : Directed and randomized self-checking bench for fetch_unit.
// Revision : 1.0
// ============================================================================
module tb_fetch_unit;

   localparam logic [31:0] NOP = 32'h0000_0013;
   localparam logic [31:0] RPC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst, StallF, StallD, PCSrcE, imem_ready, imem_req, ValidD;
   logic [31:0] PCTargetE, imem_rdata, imem_addr, InstrD, PCD, PCPlus4D;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] fetch_count, bubble_count;
`endif

   always #5 clk = ~clk;

   fetch_unit #(.RESET_PC(RPC), .NOP_INSTR(NOP)) dut (
      .clk(clk), .rst(rst), .StallF(StallF), .StallD(StallD), .PCSrcE(PCSrcE),
      .PCTargetE(PCTargetE), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ready(imem_ready), .imem_rdata(imem_rdata), .InstrD(InstrD),
      .PCD(PCD), .PCPlus4D(PCPlus4D), .ValidD(ValidD)
`ifdef FETCH_PERF_CNT_EN
      , .fetch_count(fetch_count), .bubble_count(bubble_count)
`endif
   );

   int checks = 0;
   int errors = 0;

   // stimulus knobs and memory model state
   logic        b_rst, b_stf, b_std, b_pcs;
   logic [31:0] b_tgt;
   int          lat, cnt, deliv;
   bit          rnd_lat;
   logic [31:0] exp_pc;

   // values sampled just before the active edge
   logic        p_req, p_ready, p_rst, p_pcs, p_std, p_valid;
   logic [31:0] p_addr, p_tgt, p_instr, p_pcd, p_pc4;

   function automatic logic [31:0] memf(input logic [31:0] a);
      return {a[15:0], ~a[31:16]} ^ 32'h1234_5678;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_cycle();
      if (p_rst) begin
         chk("rst_req", {31'd0, p_req}, 32'd0);
         chk("rst_valid", {31'd0, ValidD}, 32'd0);
         chk("rst_instr", InstrD, NOP);
         chk("rst_pcd", PCD, 32'd0);
         chk("rst_pc4", PCPlus4D, 32'd0);
         exp_pc = RPC;
      end else begin
         if (p_req && !p_ready) begin
            chk("hs_req_held", {31'd0, imem_req}, 32'd1);
            chk("hs_addr_held", imem_addr, p_addr);
         end else if (StallF) begin
            chk("idle_req", {31'd0, imem_req}, 32'd0);
         end
         if (p_pcs) begin
            chk("redir_valid", {31'd0, ValidD}, 32'd0);
            chk("redir_instr", InstrD, NOP);
            exp_pc = p_tgt;
         end else if (p_std) begin
            chk("hold_instr", InstrD, p_instr);
            chk("hold_pcd", PCD, p_pcd);
            chk("hold_pc4", PCPlus4D, p_pc4);
            chk("hold_valid", {31'd0, ValidD}, {31'd0, p_valid});
         end else if (ValidD) begin
            chk("seq_pcd", PCD, exp_pc);
            chk("seq_instr", InstrD, memf(exp_pc));
            chk("seq_pc4", PCPlus4D, exp_pc + 32'd4);
            exp_pc = exp_pc + 32'd4;
            deliv++;
         end else begin
            chk("bubble_instr", InstrD, NOP);
         end
      end
   endtask

   task automatic run1();
      @(negedge clk);
      rst = b_rst; StallF = b_stf; StallD = b_std; PCSrcE = b_pcs; PCTargetE = b_tgt;
      #1;
      if (imem_req && cnt >= lat) begin
         imem_ready = 1'b1;
         imem_rdata = memf(imem_addr);
      end else begin
         imem_ready = 1'b0;
         imem_rdata = $urandom;
      end
      p_req = imem_req; p_addr = imem_addr; p_ready = imem_ready; p_rst = b_rst;
      p_pcs = b_pcs; p_tgt = b_tgt; p_std = b_std;
      p_instr = InstrD; p_pcd = PCD; p_pc4 = PCPlus4D; p_valid = ValidD;
      @(posedge clk);
      #1;
      if (p_rst) begin
         cnt = 0;
      end else if (p_req && p_ready) begin
         cnt = 0;
         if (rnd_lat) lat = $urandom_range(0, 3);
      end else if (p_req) begin
         cnt++;
      end
      check_cycle();
   endtask

   initial begin
      int d0;
      rst = 1'b1; StallF = 1'b0; StallD = 1'b0; PCSrcE = 1'b0; PCTargetE = 32'd0;
      imem_ready = 1'b0; imem_rdata = 32'd0;
      b_rst = 1'b1; b_stf = 1'b0; b_std = 1'b0; b_pcs = 1'b0; b_tgt = 32'd0;
      lat = 0; cnt = 0; deliv = 0; rnd_lat = 1'b0; exp_pc = RPC;

      // zero-wait memory, no stalls
      run1(); run1();
      b_rst = 1'b0;
      for (int k = 0; k < 4; k++) begin
         run1();
         chk("zw_valid", {31'd0, ValidD}, 32'd1);
         chk("zw_pcd", PCD, 32'(k * 4));
      end

      // two-cycle latency: each address held for three cycles
      lat = 2; b_rst = 1'b1; run1(); b_rst = 1'b0;
      for (int k = 1; k <= 9; k++) begin
         run1();
         chk("lat_addr", p_addr, 32'(((k - 1) / 3) * 4));
         if (k % 3 == 0) begin
            chk("lat_valid", {31'd0, ValidD}, 32'd1);
            chk("lat_pcd", PCD, 32'((k / 3 - 1) * 4));
         end else begin
            chk("lat_bubble", {31'd0, ValidD}, 32'd0);
         end
      end

      // response lands in skid buffer during a stall
      run1();
      b_stf = 1'b1; b_std = 1'b1;
      repeat (3) run1();
      chk("skid_req_off", {31'd0, imem_req}, 32'd0);
      chk("skid_valid_held", {31'd0, ValidD}, 32'd0);
      b_stf = 1'b0; b_std = 1'b0;
      run1();
      chk("skid_valid", {31'd0, ValidD}, 32'd1);
      chk("skid_pcd", PCD, 32'h0000_000C);
      chk("skid_instr", InstrD, memf(32'h0000_000C));

      // redirect while a request to 0x8 is outstanding
      b_rst = 1'b1; run1(); b_rst = 1'b0;
      repeat (7) run1();
      b_pcs = 1'b1; b_tgt = 32'h0000_0100;
      run1();
      b_pcs = 1'b0;
      run1();
      chk("drain_addr", p_addr, 32'h0000_0008);
      chk("drain_valid", {31'd0, ValidD}, 32'd0);
      run1();
      chk("redir_req_addr", p_addr, 32'h0000_0100);
      run1(); run1();
      chk("redir_deliv_valid", {31'd0, ValidD}, 32'd1);
      chk("redir_deliv_pcd", PCD, 32'h0000_0100);

      // redirect with StallD while the skid buffer is full
      lat = 0; b_std = 1'b1;
      run1();
      b_pcs = 1'b1; b_tgt = 32'h0000_0200;
      run1();
      chk("skidflush_valid", {31'd0, ValidD}, 32'd0);
      b_pcs = 1'b0; b_std = 1'b0;
      run1();
      chk("skidflush_addr", p_addr, 32'h0000_0200);
      chk("skidflush_pcd", PCD, 32'h0000_0200);

      // reset while draining
      lat = 3;
      run1();
      b_pcs = 1'b1; b_tgt = 32'h0000_0300;
      run1();
      b_pcs = 1'b0; b_rst = 1'b1;
      run1();
      chk("rstdrain_valid", {31'd0, ValidD}, 32'd0);
`ifdef FETCH_PERF_CNT_EN
      chk("rstdrain_fetch_cnt", fetch_count, 32'd0);
      chk("rstdrain_bubble_cnt", bubble_count, 32'd0);
`endif
      b_rst = 1'b0; lat = 0;
      run1();
      chk("rstdrain_addr", p_addr, RPC);
      chk("rstdrain_pcd", PCD, RPC);

      // randomized traffic, including PC wrap past 32'hFFFF_FFFC
      rnd_lat = 1'b1;
      d0 = deliv;
      repeat (3000) begin
         b_stf = ($urandom_range(0, 3) == 0);
         b_std = ($urandom_range(0, 3) == 0);
         b_pcs = ($urandom_range(0, 19) == 0);
         b_tgt = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
         run1();
      end
      chk("progress", {31'd0, (deliv - d0) > 300}, 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
